// File: rtl/age_issue_queue.sv
// Age-ordered issue queue: slot allocation, payload storage, oldest-first multi-port issue.
// Latency: an entry enqueued at edge N can be issued in cycle N+1; issue outputs are combinational from state.
// Backpressure: enq_ready_o[j] is high when more than j slots are free; deq ports pop independently on ready.
// Optional macro AGE_ISSUE_QUEUE_FLUSH_EN enables flush_i (ignored when undefined).
module age_issue_queue #(
    parameter int unsigned NumEntries = 8,
    parameter int unsigned NumEnq     = 2,
    parameter int unsigned NumDeq     = 2,
    parameter int unsigned DataWidth  = 32,
    localparam int unsigned IdxW      = $clog2(NumEntries),
    localparam int unsigned CntW      = $clog2(NumEntries + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NumEnq-1:0]                   enq_valid_i,
    output logic [NumEnq-1:0]                   enq_ready_o,
    input  logic [NumEnq-1:0][DataWidth-1:0]    enq_data_i,
    input  logic [NumEntries-1:0]               entry_rdy_i,
    output logic [NumDeq-1:0]                   deq_valid_o,
    input  logic [NumDeq-1:0]                   deq_ready_i,
    output logic [NumDeq-1:0][DataWidth-1:0]    deq_data_o,
    output logic [NumDeq-1:0][IdxW-1:0]         deq_idx_o,
    input  logic                                flush_i,
    output logic [CntW-1:0]                     occupancy_o
);

    // age_q[r][c] = 1 means slot r is older than slot c
    logic [NumEntries-1:0]                  valid_q, valid_d;
    logic [NumEntries-1:0][NumEntries-1:0]  age_q, age_d;
    logic [DataWidth-1:0]                   data_q [NumEntries];

    logic                                   flush;
    logic [CntW-1:0]                        occ;
    logic [CntW-1:0]                        free_cnt;
    logic [NumEnq-1:0]                      enq_fire;
    logic [NumEnq-1:0][IdxW-1:0]            enq_slot;
    logic [NumEntries-1:0]                  free_rem;
    logic                                   found;
    logic [NumDeq-1:0]                      deq_fire;
    logic [NumEntries-1:0]                  cand;
    logic [IdxW:0]                          pick;

`ifdef AGE_ISSUE_QUEUE_FLUSH_EN
    assign flush = flush_i;
`else
    logic unused_flush;
    assign unused_flush = flush_i;
    assign flush        = 1'b0;
`endif

    // Oldest candidate: a candidate with no other candidate older than it.
    // Returns {found, index}.
    function automatic logic [IdxW:0] pick_oldest(
        input logic [NumEntries-1:0]                 c,
        input logic [NumEntries-1:0][NumEntries-1:0] age
    );
        logic [IdxW:0] res;
        logic          older;
        res = '0;
        for (int i = 0; i < NumEntries; i++) begin
            older = 1'b0;
            for (int j = 0; j < NumEntries; j++) begin
                if (j != i && c[j] && age[j][i]) older = 1'b1;
            end
            if (c[i] && !older) res = {1'b1, IdxW'(i)};
        end
        return res;
    endfunction

    // Occupancy is the population count of the valid vector.
    always_comb begin
        occ = '0;
        for (int i = 0; i < NumEntries; i++) occ = occ + CntW'(valid_q[i]);
        free_cnt = CntW'(NumEntries) - occ;
    end

    assign occupancy_o = occ;

    // Port j may enqueue when more than j slots are free at the start of the cycle.
    always_comb begin
        enq_ready_o = '0;
        for (int j = 0; j < NumEnq; j++) begin
            enq_ready_o[j] = !flush && (free_cnt > CntW'(j));
        end
    end

    assign enq_fire = enq_valid_i & enq_ready_o;

    // Firing ports take the lowest free slots in port order.
    always_comb begin
        free_rem = ~valid_q;
        enq_slot = '0;
        found    = 1'b0;
        for (int j = 0; j < NumEnq; j++) begin
            if (enq_fire[j]) begin
                found = 1'b0;
                for (int i = 0; i < NumEntries; i++) begin
                    if (free_rem[i] && !found) begin
                        enq_slot[j] = IdxW'(i);
                        found       = 1'b1;
                    end
                end
                free_rem[enq_slot[j]] = 1'b0;
            end
        end
    end

    // Issue: each port takes the oldest eligible entry not claimed by a lower port.
    always_comb begin
        cand        = valid_q & entry_rdy_i;
        if (flush) cand = '0;
        deq_valid_o = '0;
        deq_idx_o   = '0;
        deq_data_o  = '0;
        pick        = '0;
        for (int k = 0; k < NumDeq; k++) begin
            pick = pick_oldest(cand, age_q);
            if (pick[IdxW]) begin
                deq_valid_o[k]          = 1'b1;
                deq_idx_o[k]            = pick[IdxW-1:0];
                deq_data_o[k]           = data_q[pick[IdxW-1:0]];
                cand[pick[IdxW-1:0]]    = 1'b0;
            end
        end
    end

    assign deq_fire = deq_valid_o & deq_ready_i;

    // Next valid vector: pops clear, enqueues set, flush wipes everything.
    always_comb begin
        valid_d = valid_q;
        for (int k = 0; k < NumDeq; k++) begin
            if (deq_fire[k]) valid_d[deq_idx_o[k]] = 1'b0;
        end
        for (int j = 0; j < NumEnq; j++) begin
            if (enq_fire[j]) valid_d[enq_slot[j]] = 1'b1;
        end
        if (flush) valid_d = '0;
    end

    // Next age matrix: every existing slot becomes older than a new one (column set),
    // then the new row marks only same-cycle higher-port slots as younger; row wins.
    always_comb begin
        age_d = age_q;
        for (int j = 0; j < NumEnq; j++) begin
            if (enq_fire[j]) begin
                for (int r = 0; r < NumEntries; r++) age_d[r][enq_slot[j]] = 1'b1;
            end
        end
        for (int j = 0; j < NumEnq; j++) begin
            if (enq_fire[j]) begin
                age_d[enq_slot[j]] = '0;
                for (int h = j + 1; h < NumEnq; h++) begin
                    if (enq_fire[h]) age_d[enq_slot[j]][enq_slot[h]] = 1'b1;
                end
            end
        end
    end

    // Valid and age state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            age_q   <= '0;
        end else begin
            valid_q <= valid_d;
            age_q   <= age_d;
        end
    end

    // Payload storage; contents are meaningless while the slot is invalid, so no reset.
    always_ff @(posedge clk_i) begin
        for (int j = 0; j < NumEnq; j++) begin
            if (enq_fire[j]) data_q[enq_slot[j]] <= enq_data_i[j];
        end
    end

endmodule

// File: tb/tb_age_issue_queue.sv
// Directed bench for age_issue_queue: vector table for steady-state behaviour
// plus hand-written sequences for full/dequeue, async reset and flush.
module tb_age_issue_queue;

    localparam int NE = 8;
    localparam int DW = 32;

    logic               clk;
    logic               rst_n;
    logic [1:0]         enq_valid;
    logic [1:0]         enq_ready;
    logic [1:0][DW-1:0] enq_data;
    logic [NE-1:0]      entry_rdy;
    logic [1:0]         deq_valid;
    logic [1:0]         deq_ready;
    logic [1:0][DW-1:0] deq_data;
    logic [1:0][2:0]    deq_idx;
    logic               flush;
    logic [3:0]         occupancy;

    int n_checks = 0;
    int n_pass   = 0;

    age_issue_queue #(
        .NumEntries(NE), .NumEnq(2), .NumDeq(2), .DataWidth(DW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .enq_valid_i (enq_valid),
        .enq_ready_o (enq_ready),
        .enq_data_i  (enq_data),
        .entry_rdy_i (entry_rdy),
        .deq_valid_o (deq_valid),
        .deq_ready_i (deq_ready),
        .deq_data_o  (deq_data),
        .deq_idx_o   (deq_idx),
        .flush_i     (flush),
        .occupancy_o (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ev;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [7:0]  er;
        logic [1:0]  dr;
        logic [1:0]  x_er;
        logic [1:0]  x_dv;
        logic [2:0]  x_i0;
        logic [2:0]  x_i1;
        logic [31:0] x_d0;
        logic [31:0] x_d1;
        logic [3:0]  x_occ;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic [1:0] ev, input logic [31:0] d0, input logic [31:0] d1,
        input logic [7:0] er, input logic [1:0] dr,
        input logic [1:0] x_er, input logic [1:0] x_dv,
        input logic [2:0] x_i0, input logic [2:0] x_i1,
        input logic [31:0] x_d0, input logic [31:0] x_d1, input logic [3:0] x_occ);
        vec_t v;
        v.ev = ev; v.d0 = d0; v.d1 = d1; v.er = er; v.dr = dr;
        v.x_er = x_er; v.x_dv = x_dv; v.x_i0 = x_i0; v.x_i1 = x_i1;
        v.x_d0 = x_d0; v.x_d1 = x_d1; v.x_occ = x_occ;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic [1:0] ev, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [7:0] er, input logic [1:0] dr);
        enq_valid   = ev;
        enq_data[0] = d0;
        enq_data[1] = d1;
        entry_rdy   = er;
        deq_ready   = dr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drive(2'b00, 0, 0, 8'h00, 2'b00);

        // fill in order, then drain pairs
        vq.push_back(mk(2'b00, 32'h0,  32'h0,  8'hFF, 2'b00, 2'b11, 2'b00, 0, 0, 32'h0,  32'h0,  0));
        vq.push_back(mk(2'b11, 32'h10, 32'h11, 8'hFF, 2'b00, 2'b11, 2'b00, 0, 0, 32'h0,  32'h0,  0));
        vq.push_back(mk(2'b11, 32'h12, 32'h13, 8'hFF, 2'b00, 2'b11, 2'b11, 0, 1, 32'h10, 32'h11, 2));
        vq.push_back(mk(2'b11, 32'h14, 32'h15, 8'hFF, 2'b00, 2'b11, 2'b11, 0, 1, 32'h10, 32'h11, 4));
        vq.push_back(mk(2'b11, 32'h16, 32'h17, 8'hFF, 2'b00, 2'b11, 2'b11, 0, 1, 32'h10, 32'h11, 6));
        vq.push_back(mk(2'b11, 32'hFF, 32'hFF, 8'hFF, 2'b00, 2'b00, 2'b11, 0, 1, 32'h10, 32'h11, 8));
        vq.push_back(mk(2'b00, 32'h0,  32'h0,  8'hFF, 2'b11, 2'b00, 2'b11, 0, 1, 32'h10, 32'h11, 8));
        vq.push_back(mk(2'b00, 32'h0,  32'h0,  8'hFF, 2'b11, 2'b11, 2'b11, 2, 3, 32'h12, 32'h13, 6));
        vq.push_back(mk(2'b00, 32'h0,  32'h0,  8'hFF, 2'b11, 2'b11, 2'b11, 4, 5, 32'h14, 32'h15, 4));
        vq.push_back(mk(2'b00, 32'h0,  32'h0,  8'hFF, 2'b11, 2'b11, 2'b11, 6, 7, 32'h16, 32'h17, 2));
        vq.push_back(mk(2'b00, 32'h0,  32'h0,  8'hFF, 2'b00, 2'b11, 2'b00, 0, 0, 32'h0,  32'h0,  0));
        // out-of-order eligibility: A,B,C; only C,A eligible, then B
        vq.push_back(mk(2'b01, 32'h20, 32'h0,  8'hFF, 2'b00, 2'b11, 2'b00, 0, 0, 32'h0,  32'h0,  0));
        vq.push_back(mk(2'b01, 32'h21, 32'h0,  8'hFF, 2'b00, 2'b11, 2'b01, 0, 0, 32'h20, 32'h0,  1));
        vq.push_back(mk(2'b01, 32'h22, 32'h0,  8'hFF, 2'b00, 2'b11, 2'b11, 0, 1, 32'h20, 32'h21, 2));
        vq.push_back(mk(2'b00, 32'h0,  32'h0,  8'h05, 2'b11, 2'b11, 2'b11, 0, 2, 32'h20, 32'h22, 3));
        vq.push_back(mk(2'b00, 32'h0,  32'h0,  8'h02, 2'b11, 2'b11, 2'b01, 1, 0, 32'h21, 32'h0,  1));
        vq.push_back(mk(2'b00, 32'h0,  32'h0,  8'hFF, 2'b00, 2'b11, 2'b00, 0, 0, 32'h0,  32'h0,  0));
        // partial accept: only port1 pops, survivor moves to port0
        vq.push_back(mk(2'b11, 32'h30, 32'h31, 8'hFF, 2'b00, 2'b11, 2'b00, 0, 0, 32'h0,  32'h0,  0));
        vq.push_back(mk(2'b00, 32'h0,  32'h0,  8'hFF, 2'b10, 2'b11, 2'b11, 0, 1, 32'h30, 32'h31, 2));
        vq.push_back(mk(2'b00, 32'h0,  32'h0,  8'hFF, 2'b01, 2'b11, 2'b01, 0, 0, 32'h30, 32'h0,  1));
        vq.push_back(mk(2'b00, 32'h0,  32'h0,  8'hFF, 2'b00, 2'b11, 2'b00, 0, 0, 32'h0,  32'h0,  0));
        // age versus slot index: newer entries land in lower slots than older ones
        vq.push_back(mk(2'b01, 32'h40, 32'h0,  8'hFF, 2'b00, 2'b11, 2'b00, 0, 0, 32'h0,  32'h0,  0));
        vq.push_back(mk(2'b11, 32'h41, 32'h42, 8'hFF, 2'b00, 2'b11, 2'b01, 0, 0, 32'h40, 32'h0,  1));
        vq.push_back(mk(2'b00, 32'h0,  32'h0,  8'hFF, 2'b01, 2'b11, 2'b11, 0, 1, 32'h40, 32'h41, 3));
        vq.push_back(mk(2'b11, 32'h50, 32'h51, 8'h09, 2'b00, 2'b11, 2'b00, 0, 0, 32'h0,  32'h0,  2));
        vq.push_back(mk(2'b00, 32'h0,  32'h0,  8'hFF, 2'b11, 2'b11, 2'b11, 1, 2, 32'h41, 32'h42, 4));
        vq.push_back(mk(2'b00, 32'h0,  32'h0,  8'hFF, 2'b11, 2'b11, 2'b11, 0, 3, 32'h50, 32'h51, 2));
        vq.push_back(mk(2'b00, 32'h0,  32'h0,  8'hFF, 2'b00, 2'b11, 2'b00, 0, 0, 32'h0,  32'h0,  0));

        #12;
        rst_n = 1'b1;

        foreach (vq[i]) begin
            drive(vq[i].ev, vq[i].d0, vq[i].d1, vq[i].er, vq[i].dr);
            #2;
            check($sformatf("v%0d enq_ready", i), 64'(enq_ready),   64'(vq[i].x_er));
            check($sformatf("v%0d deq_valid", i), 64'(deq_valid),   64'(vq[i].x_dv));
            check($sformatf("v%0d deq_idx0",  i), 64'(deq_idx[0]),  64'(vq[i].x_i0));
            check($sformatf("v%0d deq_idx1",  i), 64'(deq_idx[1]),  64'(vq[i].x_i1));
            check($sformatf("v%0d deq_data0", i), 64'(deq_data[0]), 64'(vq[i].x_d0));
            check($sformatf("v%0d deq_data1", i), 64'(deq_data[1]), 64'(vq[i].x_d1));
            check($sformatf("v%0d occupancy", i), 64'(occupancy),   64'(vq[i].x_occ));
            next_cycle();
        end

        // full plus dequeue: ready rises only the cycle after the pop, new entry reuses slot 0
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, 32'h60 + 2 * c, 32'h61 + 2 * c, 8'hFF, 2'b00);
            next_cycle();
        end
        drive(2'b01, 32'h70, 32'h0, 8'hFF, 2'b01);
        #2;
        check("full enq_ready", 64'(enq_ready), 64'(2'b00));
        check("full occupancy", 64'(occupancy), 64'd8);
        check("full pop idx",   64'(deq_idx[0]), 64'd0);
        next_cycle();
        drive(2'b01, 32'h70, 32'h0, 8'hFF, 2'b00);
        #2;
        check("freed enq_ready", 64'(enq_ready), 64'(2'b01));
        check("freed occupancy", 64'(occupancy), 64'd7);
        next_cycle();
        drive(2'b00, 32'h0, 32'h0, 8'h01, 2'b00);
        #2;
        check("refill occupancy", 64'(occupancy),   64'd8);
        check("refill deq_valid", 64'(deq_valid),   64'(2'b01));
        check("refill idx",       64'(deq_idx[0]),  64'd0);
        check("refill data",      64'(deq_data[0]), 64'h70);

        // asynchronous reset mid-cycle
        rst_n = 1'b0;
        #1;
        check("arst occupancy", 64'(occupancy),   64'd0);
        check("arst deq_valid", 64'(deq_valid),   64'(2'b00));
        check("arst enq_ready", 64'(enq_ready),   64'(2'b11));
        check("arst deq_data0", 64'(deq_data[0]), 64'd0);
        check("arst deq_idx0",  64'(deq_idx[0]),  64'd0);
        #2;
        rst_n = 1'b1;
        next_cycle();
        drive(2'b01, 32'h80, 32'h0, 8'hFF, 2'b00);
        #2;
        check("post-rst occupancy", 64'(occupancy), 64'd0);
        next_cycle();
        drive(2'b00, 32'h0, 32'h0, 8'hFF, 2'b00);
        #2;
        check("post-rst occ1",  64'(occupancy),   64'd1);
        check("post-rst idx",   64'(deq_idx[0]),  64'd0);
        check("post-rst data",  64'(deq_data[0]), 64'h80);
        drive(2'b00, 32'h0, 32'h0, 8'hFF, 2'b01);
        next_cycle();

        // five entries then a flush pulse
        drive(2'b11, 32'h90, 32'h91, 8'hFF, 2'b00);
        next_cycle();
        drive(2'b11, 32'h92, 32'h93, 8'hFF, 2'b00);
        next_cycle();
        drive(2'b01, 32'h94, 32'h0, 8'hFF, 2'b00);
        next_cycle();
        drive(2'b00, 32'h0, 32'h0, 8'hFF, 2'b00);
        #2;
        check("pre-flush occupancy", 64'(occupancy), 64'd5);
        next_cycle();
`ifdef AGE_ISSUE_QUEUE_FLUSH_EN
        flush = 1'b1;
        drive(2'b11, 32'hA0, 32'hA1, 8'hFF, 2'b11);
        #2;
        check("flush enq_ready", 64'(enq_ready), 64'(2'b00));
        check("flush deq_valid", 64'(deq_valid), 64'(2'b00));
        next_cycle();
        flush = 1'b0;
        drive(2'b00, 32'h0, 32'h0, 8'hFF, 2'b00);
        #2;
        check("post-flush occupancy", 64'(occupancy), 64'd0);
        check("post-flush deq_valid", 64'(deq_valid), 64'(2'b00));
`else
        flush = 1'b1;
        #2;
        check("flush-off enq_ready", 64'(enq_ready), 64'(2'b11));
        check("flush-off deq_valid", 64'(deq_valid), 64'(2'b11));
        next_cycle();
        flush = 1'b0;
        #2;
        check("flush-off occupancy", 64'(occupancy), 64'd5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
